cam_controller: RTL and testbench

- Sequencing controller for the 32-entry exact-match CAM.
- Owns entry storage and valid bits; drives the existing equality_checker compare array; serialises LOOKUP/INSERT/DELETE/CLEAR commands from one requester.
- Uses valid/ready handshakes on both request and response, and returns hit flag, index and error.
- Sits between the query-dispatch logic and the CAM compare datapath.

---
 rtl/cam_pkg.sv | 37 +++
 rtl/cam_prio_enc.sv | 33 +++
 rtl/equality_checker.sv | 25 ++
 rtl/cam_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_cam_controller.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and width helpers for the CAM sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    typedef enum logic [1:0] {
        CAM_LOOKUP = 2'd0,
        CAM_INSERT = 2'd1,
        CAM_DELETE = 2'd2,
        CAM_CLEAR  = 2'd3
    } cam_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } cam_state_e;

    function automatic int calc_key_w(input int data_width);
        return 2 ** data_width;
    endfunction

    function automatic int calc_idx_w(input int num_comp);
        return (num_comp > 1) ? $clog2(num_comp) : 1;
    endfunction

    function automatic int calc_cnt_w(input int num_comp);
        return $clog2(num_comp + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_prio_enc.sv
// ============================================================================
// Module      : cam_prio_enc
// Description : Lowest-set-bit priority encoder with an any-bit-set flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int NUM_COMP = 32
) (
    input  logic [NUM_COMP-1:0]                   vec_i,
    output logic                                  any_o,
    output logic [calc_idx_w(NUM_COMP)-1:0]       idx_o
);

    localparam int IDX_W = calc_idx_w(NUM_COMP);

    // Scan from the top so the lowest set bit is the last assignment to win.
    always_comb begin
        any_o = |vec_i;
        idx_o = '0;
        for (int i = NUM_COMP - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/equality_checker.sv
// ============================================================================
// Module      : equality_checker
// Description : Parallel key compare against every entry, masked by valid bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equality_checker #(
    parameter int KEY_W    = 32,
    parameter int NUM_COMP = 32
) (
    input  logic [KEY_W-1:0]                 key_i,
    input  logic [NUM_COMP-1:0][KEY_W-1:0]   entries_i,
    input  logic [NUM_COMP-1:0]              valid_i,
    output logic [NUM_COMP-1:0]              match_o
);

    // Invalid entries can never match, even if their stale key equals key_i.
    for (genvar i = 0; i < NUM_COMP; i++) begin : g_cmp
        assign match_o[i] = valid_i[i] && (entries_i[i] == key_i);
    end

endmodule

`default_nettype wire

// File: rtl/cam_controller.sv
// ============================================================================
// Module      : cam_controller
// Description : Serialises LOOKUP/INSERT/DELETE/CLEAR over a 32-entry exact-
//               match CAM. Optional LOOKUP hit/miss counters: CAM_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_controller
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_COMP   = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [1:0]                            req_op_i,
    input  logic [calc_key_w(DATA_WIDTH)-1:0]     req_key_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic                                  rsp_hit_o,
    output logic [calc_idx_w(NUM_COMP)-1:0]       rsp_idx_o,
    output logic                                  rsp_err_o,
`ifdef CAM_CTRL_STATS_EN
    output logic [31:0]                           stat_hits_o,
    output logic [31:0]                           stat_miss_o,
`endif
    output logic [calc_cnt_w(NUM_COMP)-1:0]       count_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int KEY_W = calc_key_w(DATA_WIDTH);
    localparam int IDX_W = calc_idx_w(NUM_COMP);
    localparam int CNT_W = calc_cnt_w(NUM_COMP);

    cam_state_e                        state_q, state_d;
    cam_op_e                           op_q, op_d;
    logic [KEY_W-1:0]                  key_q, key_d;
    logic [NUM_COMP-1:0]               valid_q, valid_d;
    logic [NUM_COMP-1:0][KEY_W-1:0]    entry_q, entry_d;
    logic                              rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]                  rsp_idx_q, rsp_idx_d;
    logic                              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              full_q, full_d;
    logic                              empty_q, empty_d;

    logic [NUM_COMP-1:0]               match_vec;
    logic                              match_any;
    logic [IDX_W-1:0]                  match_idx;
    logic                              free_any;
    logic [IDX_W-1:0]                  free_idx;

    equality_checker #(
        .KEY_W    (KEY_W),
        .NUM_COMP (NUM_COMP)
    ) u_eq (
        .key_i     (key_q),
        .entries_i (entry_q),
        .valid_i   (valid_q),
        .match_o   (match_vec)
    );

    cam_prio_enc #(.NUM_COMP(NUM_COMP)) u_match_enc (
        .vec_i (match_vec),
        .any_o (match_any),
        .idx_o (match_idx)
    );

    cam_prio_enc #(.NUM_COMP(NUM_COMP)) u_free_enc (
        .vec_i (~valid_q),
        .any_o (free_any),
        .idx_o (free_idx)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        key_d     = key_q;
        valid_d   = valid_q;
        entry_d   = entry_q;
        rsp_hit_d = rsp_hit_q;
        rsp_idx_d = rsp_idx_q;
        rsp_err_d = rsp_err_q;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = cam_op_e'(req_op_i);
                    key_d   = req_key_i;
                    state_d = CMP;
                end
            end
            CMP: begin
                state_d   = RSP;
                rsp_hit_d = 1'b0;
                rsp_idx_d = '0;
                rsp_err_d = 1'b0;
                case (op_q)
                    CAM_LOOKUP: begin
                        rsp_hit_d = match_any;
                        rsp_idx_d = match_any ? match_idx : '0;
                    end
                    CAM_INSERT: begin
                        if (match_any) begin
                            rsp_hit_d = 1'b1;
                            rsp_idx_d = match_idx;
                        end else if (free_any) begin
                            entry_d[free_idx] = key_q;
                            valid_d[free_idx] = 1'b1;
                            rsp_idx_d         = free_idx;
                            count_d           = count_q + CNT_W'(1);
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    CAM_DELETE: begin
                        if (match_any) begin
                            valid_d[match_idx] = 1'b0;
                            rsp_hit_d          = 1'b1;
                            rsp_idx_d          = match_idx;
                            count_d            = count_q - CNT_W'(1);
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    default: begin
                        valid_d = '0;
                        count_d = '0;
                    end
                endcase
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d  = (count_d == CNT_W'(NUM_COMP));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            rsp_hit_q <= 1'b0;
            rsp_idx_q <= '0;
            rsp_err_q <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_err_q <= rsp_err_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    // Key storage keeps its contents across reset; reset only blocks a pending write.
    always_ff @(posedge clk_i) begin
        op_q  <= op_d;
        key_q <= key_d;
        if (!rst_i) begin
            entry_q <= entry_d;
        end
    end

`ifdef CAM_CTRL_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_hits_d = stat_hits_q;
        stat_miss_d = stat_miss_q;
        if (state_q == CMP) begin
            if (op_q == CAM_CLEAR) begin
                stat_hits_d = '0;
                stat_miss_d = '0;
            end else if (op_q == CAM_LOOKUP) begin
                if (match_any && (stat_hits_q != '1)) begin
                    stat_hits_d = stat_hits_q + 32'd1;
                end
                if (!match_any && (stat_miss_q != '1)) begin
                    stat_miss_d = stat_miss_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hits_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_hits_q <= stat_hits_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hits_o = stat_hits_q;
    assign stat_miss_o = stat_miss_q;
`endif

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_err_o   = rsp_err_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_controller.sv
// ============================================================================
// Module      : tb_cam_controller
// Description : Self-checking bench for cam_controller against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_controller;

    localparam int NC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_key;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [4:0]  rsp_idx;
    logic        rsp_err;
    logic [5:0]  count;
    logic        full;
    logic        empty;
`ifdef CAM_CTRL_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_miss;
`endif

    always #5 clk = ~clk;

    cam_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_key_i   (req_key),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_hit_o   (rsp_hit),
        .rsp_idx_o   (rsp_idx),
        .rsp_err_o   (rsp_err),
`ifdef CAM_CTRL_STATS_EN
        .stat_hits_o (stat_hits),
        .stat_miss_o (stat_miss),
`endif
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a table of (valid, key) slots filled lowest-first.
    bit          m_valid [NC];
    logic [31:0] m_key   [NC];
    logic        e_hit;
    int          e_idx;
    logic        e_err;

    // Response captured by do_cmd.
    int          r_lat;
    logic        r_hit;
    logic [4:0]  r_idx;
    logic        r_err;
    logic [5:0]  r_cnt;
    logic        r_full;
    logic        r_empty;

    function automatic void model_apply(input int op, input logic [31:0] key);
        int m = -1;
        int f = -1;
        for (int i = 0; i < NC; i++) begin
            if (m < 0 && m_valid[i] && m_key[i] == key) m = i;
            if (f < 0 && !m_valid[i]) f = i;
        end
        e_hit = 1'b0; e_idx = 0; e_err = 1'b0;
        case (op)
            0: if (m >= 0) begin e_hit = 1'b1; e_idx = m; end
            1: if (m >= 0) begin e_hit = 1'b1; e_idx = m; end
               else if (f >= 0) begin m_valid[f] = 1'b1; m_key[f] = key; e_idx = f; end
               else e_err = 1'b1;
            2: if (m >= 0) begin e_hit = 1'b1; e_idx = m; m_valid[m] = 1'b0; end
               else e_err = 1'b1;
            default: for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
        endcase
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NC; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic bit model_has(input logic [31:0] key);
        for (int i = 0; i < NC; i++) if (m_valid[i] && m_key[i] == key) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one command and capture the response at the first cycle rsp_valid_o is seen.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] key, input logic rdy);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key; rsp_ready = rdy;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_key = $urandom;
        r_lat = 0;
        for (int n = 1; n <= 8 && r_lat == 0; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r_lat = n; r_hit = rsp_hit; r_idx = rsp_idx; r_err = rsp_err;
                r_cnt = count; r_full = full; r_empty = empty;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_key = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
        vectors++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err, count, full, empty} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b hit=%b idx=%0d err=%b cnt=%0d full=%b empty=%b, want rdy=1 vld=0 hit=0 idx=0 err=0 cnt=0 full=0 empty=1",
                     req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err, count, full, empty);
        end
    endtask

    task automatic test_insert_lookup();
        do_cmd(2'd1, 32'hDEADBEEF, 1'b1);
        model_apply(1, 32'hDEADBEEF);
        vectors++;
        if (r_lat !== 2) begin miscompares++; $display("FAIL first_latency: got %0d cycles, want 2", r_lat); end
        vectors++;
        if ({r_hit, r_idx, r_err, r_cnt, r_empty} !== {1'b0, 5'd0, 1'b0, 6'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL first_insert: got hit=%b idx=%0d err=%b cnt=%0d empty=%b, want 0 0 0 1 0", r_hit, r_idx, r_err, r_cnt, r_empty);
        end
        for (int k = 0; k < 2; k++) begin
            do_cmd(k == 0 ? 2'd1 : 2'd0, 32'hDEADBEEF, 1'b1);
            model_apply(k == 0 ? 1 : 0, 32'hDEADBEEF);
            vectors++;
            if ({r_lat == 2, r_hit, r_idx, r_err, r_cnt} !== {1'b1, 1'b1, 5'd0, 1'b0, 6'd1}) begin
                miscompares++;
                $display("FAIL repeat_key_%0d: got lat=%0d hit=%b idx=%0d err=%b cnt=%0d, want lat=2 hit=1 idx=0 err=0 cnt=1", k, r_lat, r_hit, r_idx, r_err, r_cnt);
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] key;
        for (int s = 1; s < NC; s++) begin
            do begin
                key = $urandom;
            end while (model_has(key) || key == 32'h0 || key == 32'h12345678 || key == 32'hCAFEF00D);
            do_cmd(2'd1, key, 1'b1);
            model_apply(1, key);
            vectors++;
            if ({r_lat == 2, r_hit, r_idx, r_err, r_cnt} !== {1'b1, 1'b0, 5'(s), 1'b0, 6'(s + 1)}) begin
                miscompares++;
                $display("FAIL fill_slot_%0d: got lat=%0d hit=%b idx=%0d err=%b cnt=%0d, want lat=2 hit=0 idx=%0d err=0 cnt=%0d",
                         s, r_lat, r_hit, r_idx, r_err, r_cnt, s, s + 1);
            end
        end
        do_cmd(2'd1, 32'h12345678, 1'b1);
        model_apply(1, 32'h12345678);
        vectors++;
        if ({r_hit, r_idx, r_err, r_cnt, r_full, r_empty} !== {1'b0, 5'd0, 1'b1, 6'd32, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL insert_full: got hit=%b idx=%0d err=%b cnt=%0d full=%b empty=%b, want 0 0 1 32 1 0", r_hit, r_idx, r_err, r_cnt, r_full, r_empty);
        end
        do_cmd(2'd0, 32'h12345678, 1'b1);
        model_apply(0, 32'h12345678);
        vectors++;
        if ({r_hit, r_idx, r_err} !== {1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL lookup_rejected: got hit=%b idx=%0d err=%b, want 0 0 0", r_hit, r_idx, r_err);
        end
    endtask

    task automatic test_delete_reinsert();
        logic [31:0] key5;
        key5 = m_key[5];
        do_cmd(2'd2, key5, 1'b1);
        model_apply(2, key5);
        vectors++;
        if ({r_hit, r_idx, r_err, r_cnt, r_full} !== {1'b1, 5'd5, 1'b0, 6'd31, 1'b0}) begin
            miscompares++;
            $display("FAIL delete_slot5: got hit=%b idx=%0d err=%b cnt=%0d full=%b, want 1 5 0 31 0", r_hit, r_idx, r_err, r_cnt, r_full);
        end
        do_cmd(2'd1, 32'hCAFEF00D, 1'b1);
        model_apply(1, 32'hCAFEF00D);
        vectors++;
        if ({r_hit, r_idx, r_err, r_cnt, r_full} !== {1'b0, 5'd5, 1'b0, 6'd32, 1'b1}) begin
            miscompares++;
            $display("FAIL reinsert_free: got hit=%b idx=%0d err=%b cnt=%0d full=%b, want 0 5 0 32 1", r_hit, r_idx, r_err, r_cnt, r_full);
        end
        do_cmd(2'd2, 32'h0, 1'b1);
        model_apply(2, 32'h0);
        vectors++;
        if ({r_hit, r_idx, r_err, r_cnt} !== {1'b0, 5'd0, 1'b1, 6'd32}) begin
            miscompares++;
            $display("FAIL delete_absent: got hit=%b idx=%0d err=%b cnt=%0d, want 0 0 1 32", r_hit, r_idx, r_err, r_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_cmd(2'd0, 32'hDEADBEEF, 1'b0);
        model_apply(0, 32'hDEADBEEF);
        vectors++;
        if ({r_lat == 2, r_hit, r_idx} !== {1'b1, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL stall_first: got lat=%0d hit=%b idx=%0d, want lat=2 hit=1 idx=0", r_lat, r_hit, r_idx);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_hit, rsp_idx, rsp_err, req_ready} !== {1'b1, 1'b1, 5'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got vld=%b hit=%b idx=%0d err=%b rdy=%b, want 1 1 0 0 0", k, rsp_valid, rsp_hit, rsp_idx, rsp_err, req_ready);
            end
            req_valid = k[0]; req_op = 2'd3; req_key = $urandom;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, count} !== {1'b1, 1'b0, 6'(model_count())}) begin
            miscompares++;
            $display("FAIL stall_release: got rdy=%b vld=%b cnt=%0d, want rdy=1 vld=0 cnt=%0d", req_ready, rsp_valid, count, model_count());
        end
    endtask

    task automatic test_reset_mid();
        do_cmd(2'd3, 32'h0, 1'b1);
        model_apply(3, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            do_cmd(2'd1, 32'h1111_1111 * k, 1'b1);
            model_apply(1, 32'h1111_1111 * k);
        end
        do_cmd(2'd0, 32'h22222222, 1'b0);
        vectors++;
        if ({r_lat == 2, r_hit, r_idx, r_cnt} !== {1'b1, 1'b1, 5'd1, 6'd3}) begin
            miscompares++;
            $display("FAIL pre_reset: got lat=%0d hit=%b idx=%0d cnt=%0d, want lat=2 hit=1 idx=1 cnt=3", r_lat, r_hit, r_idx, r_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready, count, empty, full, rsp_hit, rsp_idx} !== {1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_in_rsp: got vld=%b rdy=%b cnt=%0d empty=%b full=%b hit=%b idx=%0d, want 0 1 0 1 0 0 0",
                     rsp_valid, req_ready, count, empty, full, rsp_hit, rsp_idx);
        end
        do_cmd(2'd0, 32'h22222222, 1'b1);
        model_apply(0, 32'h22222222);
        vectors++;
        if ({r_lat == 2, r_hit, r_err, r_cnt} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL lookup_after_reset: got lat=%0d hit=%b err=%b cnt=%0d, want lat=2 hit=0 err=0 cnt=0", r_lat, r_hit, r_err, r_cnt);
        end
    endtask

    task automatic test_random();
        int          op;
        int          sel;
        logic [31:0] key;
        logic [14:0] got, exp;
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 99));
            op  = (sel < 35) ? 0 : (sel < 75) ? 1 : (sel < 97) ? 2 : 3;
            key = 32'($urandom_range(0, 47)) * 32'h0101_0101 ^ 32'h5A5A_0000;
            if ($urandom_range(0, 9) == 0) key = 32'h0;
            do_cmd(2'(op), key, 1'b1);
            model_apply(op, key);
            got = {r_lat == 2, r_hit, r_idx, r_err, r_cnt, r_full};
            exp = {1'b1, e_hit, 5'(e_idx), e_err, 6'(model_count()), model_count() == NC};
            vectors++;
            if (got !== exp || r_empty !== (model_count() == 0)) begin
                miscompares++;
                $display("FAIL random_%0d op=%0d key=%h: got lat=%0d hit=%b idx=%0d err=%b cnt=%0d full=%b empty=%b, want lat=2 hit=%b idx=%0d err=%b cnt=%0d full=%b empty=%b",
                         n, op, key, r_lat, r_hit, r_idx, r_err, r_cnt, r_full, r_empty,
                         e_hit, e_idx, e_err, model_count(), model_count() == NC, model_count() == 0);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_insert_lookup();
        test_fill();
        test_delete_reinsert();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
